// File: rtl/b01_serial_adder_fsm.sv
// ============================================================================
// Module   : b01_serial_adder_fsm
// Brief    : Serial LSB-first 4-bit frame adder with carry-out overflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module b01_serial_adder_fsm (
  input  logic clock,
  input  logic reset,
  input  logic line1,
  input  logic line2,
  input  logic __obs,
  output logic outp,
  output logic overflw
);

  // No-carry positions 0..3 on A,B,C,WF0; carry positions 1..3 on F,G,WF1.
  // E is position 0 of a frame that follows a carry-out.
  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_B   = 3'd1,
    S_C   = 3'd2,
    S_WF0 = 3'd3,
    S_F   = 3'd4,
    S_G   = 3'd5,
    S_WF1 = 3'd6,
    S_E   = 3'd7
  } state_t;

  state_t state_q;
  logic   outp_q;
  logic   overflw_q;

  logic w_and;
  logic w_or;
  logic w_x;
  logic w_unused_obs;

  assign w_and = line1 & line2;
  assign w_or  = line1 | line2;
  assign w_x   = line1 ^ line2;

  // The observation strobe is deliberately kept out of every functional path.
  assign w_unused_obs = __obs;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_A;
      outp_q    <= 1'b0;
      overflw_q <= 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          state_q   <= w_and ? S_F : S_B;
          outp_q    <= w_x;
          overflw_q <= 1'b0;
        end
        S_E: begin
          state_q   <= w_and ? S_F : S_B;
          outp_q    <= w_x;
          overflw_q <= 1'b1;
        end
        S_B: begin
          state_q   <= w_and ? S_G : S_C;
          outp_q    <= w_x;
          overflw_q <= 1'b0;
        end
        S_F: begin
          state_q   <= w_or ? S_G : S_C;
          outp_q    <= ~w_x;
          overflw_q <= 1'b0;
        end
        S_C: begin
          state_q   <= w_and ? S_WF1 : S_WF0;
          outp_q    <= w_x;
          overflw_q <= 1'b0;
        end
        S_G: begin
          state_q   <= w_or ? S_WF1 : S_WF0;
          outp_q    <= ~w_x;
          overflw_q <= 1'b0;
        end
        S_WF0: begin
          state_q   <= w_and ? S_E : S_A;
          outp_q    <= w_x;
          overflw_q <= 1'b0;
        end
        S_WF1: begin
          state_q   <= w_or ? S_E : S_A;
          outp_q    <= ~w_x;
          overflw_q <= 1'b0;
        end
        default: begin
          state_q   <= S_A;
          outp_q    <= 1'b0;
          overflw_q <= 1'b0;
        end
      endcase
    end
  end

  assign outp    = outp_q;
  assign overflw = overflw_q;

endmodule

`default_nettype wire

// File: tb/tb_b01_serial_adder_fsm.sv
// ============================================================================
// Module   : tb_b01_serial_adder_fsm
// Brief    : Directed self-checking bench for the serial frame adder FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_b01_serial_adder_fsm;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic line1 = 1'b0;
  logic line2 = 1'b0;
  logic obs   = 1'b0;
  logic outp;
  logic overflw;

  int checks   = 0;
  int failures = 0;
  logic randomize_obs = 1'b0;

  b01_serial_adder_fsm dut (
    .clock   (clock),
    .reset   (reset),
    .line1   (line1),
    .line2   (line2),
    .__obs   (obs),
    .outp    (outp),
    .overflw (overflw)
  );

  always #5 clock = ~clock;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic a, input logic b,
                      input logic exp_outp, input logic exp_ovf, input string tag);
    @(negedge clock);
    reset = rst;
    line1 = a;
    line2 = b;
    if (randomize_obs) obs = 1'($urandom_range(0, 1));
    @(posedge clock);
    #1;
    checks++;
    assert (outp === exp_outp) else begin
      failures++;
      $error("FAIL %s outp observed=%b expected=%b", tag, outp, exp_outp);
    end
    checks++;
    assert (overflw === exp_ovf) else begin
      failures++;
      $error("FAIL %s overflw observed=%b expected=%b", tag, overflw, exp_ovf);
    end
  endtask

  task automatic carry_run(input string tag);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {tag, "_rst"});
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, {tag, "_b0"});  // A -> F
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, {tag, "_b1"});  // F -> G
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, {tag, "_b2"});  // G -> WF1
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, {tag, "_b3"});  // WF1 -> E
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, {tag, "_e"});   // E -> F, carry dropped
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, {tag, "_f"});   // F -> G
  endtask

  initial begin
    // Reset with inputs that would otherwise produce a 1
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "s1_rst");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "s1_a");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "s1_b");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "s1_c");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "s1_wf0");
    // Back in A: 1+1 sums to 0 with no overflow on the following frame start
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "s1_backA");

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "s2_rst");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "s2_0");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "s2_1");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "s2_2");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "s2_3");
    // Frame ended with no carry: A -> B, sum bit of 1+0, no overflow
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "s2_next");

    carry_run("s3");

    // F with (1,0) -> G: G with (0,0) yields ~0 = 1
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "s4a_rst");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "s4a_toF");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "s4a_F10");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "s4a_inG");
    // F with (0,0) -> C: C with (0,0) yields 0
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "s4b_rst");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "s4b_toF");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "s4b_F00");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "s4b_inC");

    // Reset in G discards the carry: a fresh 1+0 frame sums to all ones
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "s5_rst0");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "s5_toF");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "s5_toG");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "s5_rstG");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "s5_0");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "s5_1");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "s5_2");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "s5_3");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "s5_nextA");

    randomize_obs = 1'b1;
    carry_run("s6");
    randomize_obs = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
